// File: rtl/riscv_v_div.sv
// riscv_v_div: vector integer divide / remainder. One shared restoring divider
// walks the packed elements from element 0 upward, one quotient bit per cycle.
module riscv_v_div #(
   parameter int DATA_WIDTH = 128,
   parameter int BYTE_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  is_rem,
   input  logic                  is_signed,
   input  logic [4:0]            osize_vector,
   input  logic [DATA_WIDTH-1:0] srca,
   input  logic [DATA_WIDTH-1:0] srcb,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result
);
   localparam int EW   = 128;
   localparam int NMAX = DATA_WIDTH / BYTE_WIDTH;
   localparam int IW   = $clog2(NMAX + 1);
   localparam int CW   = $clog2(EW + 1);
   localparam logic [EW-1:0] ONE_E = {{(EW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [IW-1:0] ONE_I = {{(IW-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      DIV  = 3'd2,
      POST = 3'd3,
      DONE = 3'd4
   } state_t;

   function automatic logic [EW-1:0] neg_w(input logic [EW-1:0] x, input logic [EW-1:0] mask);
      neg_w = (~x + ONE_E) & mask;
   endfunction

   state_t                state_r;
   logic                  in_ready_r;
   logic                  out_valid_r;
   logic [DATA_WIDTH-1:0] result_r;
   logic [DATA_WIDTH-1:0] srca_r;
   logic [DATA_WIDTH-1:0] srcb_r;
   logic                  is_rem_r;
   logic                  is_signed_r;
   logic [2:0]            size_k_r;
   logic [IW-1:0]         elem_r;
   logic [CW-1:0]         cnt_r;
   logic [EW-1:0]         rem_r;
   logic [EW-1:0]         dq_r;
   logic [EW-1:0]         dvs_r;
   logic                  q_neg_r;
   logic                  r_neg_r;
   logic                  div0_r;

   logic [2:0]    size_k_s;
   logic          size_go_s;
   logic [CW-1:0] w_s;
   logic [CW-1:0] lsh_s;
   logic [IW-1:0] n_s;
   int unsigned   off_s;
   logic [EW-1:0] mask_s;
   logic [EW-1:0] top_s;
   logic [EW-1:0] a_elem_s;
   logic [EW-1:0] b_elem_s;
   logic          sign_a_s;
   logic          sign_b_s;
   logic [EW-1:0] mag_a_s;
   logic [EW-1:0] mag_b_s;
   logic [EW:0]   rem_sh_s;
   logic          ge_s;
   logic [EW-1:0] diff_s;
   logic [EW-1:0] q_fin_s;
   logic [EW-1:0] r_fin_s;
   logic [EW-1:0] val_s;

   // Size decode of the incoming request: lowest set bit wins.
   always_comb begin
      size_k_s = 3'd0;
      if (osize_vector[0]) begin
         size_k_s = 3'd0;
      end else if (osize_vector[1]) begin
         size_k_s = 3'd1;
      end else if (osize_vector[2]) begin
         size_k_s = 3'd2;
      end else if (osize_vector[3]) begin
         size_k_s = 3'd3;
      end else if (osize_vector[4]) begin
         size_k_s = 3'd4;
      end else begin
         size_k_s = 3'd0;
      end
      size_go_s = (|osize_vector) && ((IW'(NMAX) >> size_k_s) != {IW{1'b0}});
   end

   // Element extraction, sign handling and one restoring-divider step.
   always_comb begin
      w_s      = CW'(BYTE_WIDTH) << size_k_r;
      lsh_s    = CW'(EW) - w_s;
      n_s      = IW'(NMAX) >> size_k_r;
      mask_s   = {EW{1'b1}} >> lsh_s;
      top_s    = mask_s & ~(mask_s >> 1);
      off_s    = 32'(elem_r) * 32'(w_s);
      a_elem_s = EW'(srca_r >> off_s) & mask_s;
      b_elem_s = EW'(srcb_r >> off_s) & mask_s;
      sign_a_s = is_signed_r & (|(a_elem_s & top_s));
      sign_b_s = is_signed_r & (|(b_elem_s & top_s));
      mag_a_s  = sign_a_s ? neg_w(a_elem_s, mask_s) : a_elem_s;
      mag_b_s  = sign_b_s ? neg_w(b_elem_s, mask_s) : b_elem_s;
      // Dividend is left-aligned in dq_r so its next bit is always the MSB.
      rem_sh_s = {rem_r, dq_r[EW-1]};
      ge_s     = rem_sh_s >= {1'b0, dvs_r};
      diff_s   = rem_sh_s[EW-1:0] - dvs_r;
      q_fin_s  = div0_r ? mask_s : (q_neg_r ? neg_w(dq_r & mask_s, mask_s) : (dq_r & mask_s));
      r_fin_s  = r_neg_r ? neg_w(rem_r & mask_s, mask_s) : (rem_r & mask_s);
      val_s    = is_rem_r ? r_fin_s : q_fin_s;
   end

   // Control FSM, operand capture, divider datapath and result assembly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         result_r    <= {DATA_WIDTH{1'b0}};
         srca_r      <= {DATA_WIDTH{1'b0}};
         srcb_r      <= {DATA_WIDTH{1'b0}};
         is_rem_r    <= 1'b0;
         is_signed_r <= 1'b0;
         size_k_r    <= 3'd0;
         elem_r      <= {IW{1'b0}};
         cnt_r       <= {CW{1'b0}};
         rem_r       <= {EW{1'b0}};
         dq_r        <= {EW{1'b0}};
         dvs_r       <= {EW{1'b0}};
         q_neg_r     <= 1'b0;
         r_neg_r     <= 1'b0;
         div0_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  srca_r      <= srca;
                  srcb_r      <= srcb;
                  is_rem_r    <= is_rem;
                  is_signed_r <= is_signed;
                  size_k_r    <= size_k_s;
                  elem_r      <= {IW{1'b0}};
                  result_r    <= {DATA_WIDTH{1'b0}};
                  in_ready_r  <= 1'b0;
                  if (size_go_s) begin
                     state_r <= LOAD;
                  end else begin
                     state_r     <= DONE;
                     out_valid_r <= 1'b1;
                  end
               end
            end
            LOAD: begin
               dq_r    <= mag_a_s << lsh_s;
               dvs_r   <= mag_b_s;
               rem_r   <= {EW{1'b0}};
               cnt_r   <= {CW{1'b0}};
               div0_r  <= (b_elem_s == {EW{1'b0}});
               q_neg_r <= sign_a_s ^ sign_b_s;
               r_neg_r <= sign_a_s;
               state_r <= DIV;
            end
            DIV: begin
               rem_r <= ge_s ? diff_s : rem_sh_s[EW-1:0];
               dq_r  <= {dq_r[EW-2:0], ge_s};
               cnt_r <= cnt_r + ONE_C;
               if (cnt_r == w_s - ONE_C) begin
                  state_r <= POST;
               end
            end
            POST: begin
               result_r <= result_r | (DATA_WIDTH'(val_s) << off_s);
               if (elem_r == n_s - ONE_I) begin
                  state_r     <= DONE;
                  out_valid_r <= 1'b1;
               end else begin
                  elem_r  <= elem_r + ONE_I;
                  state_r <= LOAD;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_r     <= IDLE;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               state_r     <= IDLE;
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign result    = result_r;
endmodule

// File: tb/tb_riscv_v_div.sv
// Directed self-checking bench for riscv_v_div with hand-computed vectors.
module tb_riscv_v_div;
   localparam int DW = 128;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic          is_rem;
   logic          is_signed;
   logic [4:0]    osize_vector;
   logic [DW-1:0] srca;
   logic [DW-1:0] srcb;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   riscv_v_div #(.DATA_WIDTH(DW), .BYTE_WIDTH(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .is_rem       (is_rem),
      .is_signed    (is_signed),
      .osize_vector (osize_vector),
      .srca         (srca),
      .srcb         (srcb),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result)
   );

   always #5 clk = ~clk;

   // Issue one request, then wait (bounded) for out_valid; lat counts from the accept cycle.
   task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic rem,
                        input logic sgn, input logic [4:0] osz,
                        output int lat, output logic [DW-1:0] res);
      @(negedge clk);
      srca = a; srcb = b; is_rem = rem; is_signed = sgn; osize_vector = osz; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 400) begin
         @(posedge clk);
         #1 lat++;
      end
      res = result;
   endtask

   task automatic finish_op;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset;
      #12;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (result !== {DW{1'b0}}) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_e8_unsigned;
      int lat; logic [DW-1:0] res;
      do_op({16{8'hC8}}, {16{8'h07}}, 1'b0, 1'b0, 5'b00001, lat, res);
      n_checks++; if (res !== {16{8'h1C}}) begin n_fail++; $display("FAIL e8_quot: got %h expected %h", res, {16{8'h1C}}); end
      n_checks++; if (lat != 161) begin n_fail++; $display("FAIL e8_latency: got %0d expected 161", lat); end
      finish_op();
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL e8_idle: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
   endtask

   task automatic test_e32_signed;
      int lat; logic [DW-1:0] res;
      logic [DW-1:0] a, b;
      a = {32'hFFFFFFF8, 32'h00000007, 32'h00000064, 32'hFFFFFFF9};
      b = {32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000007, 32'h00000002};
      do_op(a, b, 1'b1, 1'b1, 5'b00100, lat, res);
      n_checks++; if (res !== {32'hFFFFFFFE, 32'h00000001, 32'h00000002, 32'hFFFFFFFF}) begin n_fail++; $display("FAIL e32_srem: got %h expected fffffffe0000000100000002ffffffff", res); end
      n_checks++; if (lat != 137) begin n_fail++; $display("FAIL e32_latency: got %0d expected 137", lat); end
      finish_op();
      do_op(a, b, 1'b0, 1'b1, 5'b00100, lat, res);
      n_checks++; if (res !== {32'h00000002, 32'hFFFFFFFD, 32'h0000000E, 32'hFFFFFFFD}) begin n_fail++; $display("FAIL e32_squot: got %h expected 00000002fffffffd0000000efffffffd", res); end
      finish_op();
      do_op({4{32'hFFFFFFF9}}, {4{32'h00000002}}, 1'b0, 1'b0, 5'b00100, lat, res);
      n_checks++; if (res !== {4{32'h7FFFFFFC}}) begin n_fail++; $display("FAIL e32_uquot: got %h expected %h", res, {4{32'h7FFFFFFC}}); end
      finish_op();
   endtask

   task automatic test_div_zero;
      int lat; logic [DW-1:0] res;
      do_op({8{16'h1234}}, {DW{1'b0}}, 1'b0, 1'b0, 5'b00010, lat, res);
      n_checks++; if (res !== {8{16'hFFFF}}) begin n_fail++; $display("FAIL dz_quot: got %h expected %h", res, {8{16'hFFFF}}); end
      n_checks++; if (lat != 145) begin n_fail++; $display("FAIL dz_latency: got %0d expected 145", lat); end
      finish_op();
      do_op({8{16'h1234}}, {DW{1'b0}}, 1'b1, 1'b0, 5'b00010, lat, res);
      n_checks++; if (res !== {8{16'h1234}}) begin n_fail++; $display("FAIL dz_rem: got %h expected %h", res, {8{16'h1234}}); end
      finish_op();
      do_op({8{16'h8765}}, {DW{1'b0}}, 1'b0, 1'b1, 5'b00010, lat, res);
      n_checks++; if (res !== {8{16'hFFFF}}) begin n_fail++; $display("FAIL dz_squot: got %h expected %h", res, {8{16'hFFFF}}); end
      finish_op();
      do_op({8{16'h8765}}, {DW{1'b0}}, 1'b1, 1'b1, 5'b00010, lat, res);
      n_checks++; if (res !== {8{16'h8765}}) begin n_fail++; $display("FAIL dz_srem: got %h expected %h", res, {8{16'h8765}}); end
      finish_op();
   endtask

   task automatic test_overflow;
      int lat; logic [DW-1:0] res;
      do_op({2{64'h8000000000000000}}, {DW{1'b1}}, 1'b0, 1'b1, 5'b01000, lat, res);
      n_checks++; if (res !== {2{64'h8000000000000000}}) begin n_fail++; $display("FAIL ovf_quot: got %h expected %h", res, {2{64'h8000000000000000}}); end
      n_checks++; if (lat != 133) begin n_fail++; $display("FAIL ovf_latency: got %0d expected 133", lat); end
      finish_op();
      do_op({2{64'h8000000000000000}}, {DW{1'b1}}, 1'b1, 1'b1, 5'b01000, lat, res);
      n_checks++; if (res !== {DW{1'b0}}) begin n_fail++; $display("FAIL ovf_rem: got %h expected 0", res); end
      finish_op();
   endtask

   task automatic test_multi_bit_size;
      int lat; logic [DW-1:0] res;
      do_op({8{16'h03E8}}, {8{16'h000A}}, 1'b0, 1'b0, 5'b10110, lat, res);
      n_checks++; if (res !== {8{16'h0064}}) begin n_fail++; $display("FAIL multi_size_quot: got %h expected %h", res, {8{16'h0064}}); end
      n_checks++; if (lat != 145) begin n_fail++; $display("FAIL multi_size_latency: got %0d expected 145", lat); end
      finish_op();
   endtask

   task automatic test_zero_size;
      int lat; logic [DW-1:0] res;
      do_op({16{8'h55}}, {16{8'h03}}, 1'b0, 1'b0, 5'b00000, lat, res);
      n_checks++; if (res !== {DW{1'b0}}) begin n_fail++; $display("FAIL zero_size_result: got %h expected 0", res); end
      n_checks++; if (lat != 1) begin n_fail++; $display("FAIL zero_size_latency: got %0d expected 1", lat); end
      finish_op();
   endtask

   task automatic test_backpressure;
      int lat; logic [DW-1:0] res;
      do_op({16{8'h64}}, {16{8'h09}}, 1'b1, 1'b0, 5'b00001, lat, res);
      n_checks++; if (res !== {16{8'h01}}) begin n_fail++; $display("FAIL bp_rem: got %h expected %h", res, {16{8'h01}}); end
      @(negedge clk);
      srca = {DW{1'b1}}; srcb = {16{8'h01}}; osize_vector = 5'b00001; in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         n_checks++; if (result !== {16{8'h01}} || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_hold cycle %0d: got result=%h in_ready=%b out_valid=%b expected %h/0/1", i, result, in_ready, out_valid, {16{8'h01}});
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      finish_op();
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
      n_checks++; if (result !== {16{8'h01}}) begin n_fail++; $display("FAIL bp_result_kept: got %h expected %h", result, {16{8'h01}}); end
   endtask

   task automatic test_reset_mid;
      int lat; int seen; logic [DW-1:0] res;
      @(negedge clk);
      srca = {16{8'hC8}}; srcb = {16{8'h07}}; is_rem = 1'b0; is_signed = 1'b0; osize_vector = 5'b00001; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (49) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flags: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
      n_checks++; if (result !== {DW{1'b0}}) begin n_fail++; $display("FAIL mid_reset_result: got %h expected 0", result); end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (200) begin
         @(posedge clk);
         #1 if (out_valid === 1'b1) seen++;
      end
      n_checks++; if (seen != 0) begin n_fail++; $display("FAIL mid_reset_no_valid: got %0d valid cycles expected 0", seen); end
      do_op({{120{1'b0}}, 8'h64}, {{120{1'b0}}, 8'h0A}, 1'b0, 1'b0, 5'b10000, lat, res);
      n_checks++; if (res !== {{120{1'b0}}, 8'h0A}) begin n_fail++; $display("FAIL e128_quot: got %h expected 0a", res); end
      n_checks++; if (lat != 131) begin n_fail++; $display("FAIL e128_latency: got %0d expected 131", lat); end
      finish_op();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; is_rem = 1'b0; is_signed = 1'b0;
      osize_vector = 5'b00000; srca = {DW{1'b0}}; srcb = {DW{1'b0}};
      test_reset();
      test_e8_unsigned();
      test_e32_signed();
      test_div_zero();
      test_overflow();
      test_multi_bit_size();
      test_zero_size();
      test_backpressure();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
